sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//  Single-clock, parametrised FIFO; next generation of the afifo buffer for same-domain paths.
//  Adds configurable depth, occupancy count, programmable almost-full/almost-empty flags,
//  and a full-plus-read write pass-through. Optional sticky overflow/underflow error flags.
// PARAMETERS
//  DATA_WIDTH    32  width of data_w / data_r
//  DEPTH         16  entries; power of two, >= 4
//  AFULL_THRESH  14  almost_full_o asserts when level >= AFULL_THRESH (1..DEPTH-1)
//  AEMPTY_THRESH 2   almost_empty_o asserts when level <= AEMPTY_THRESH (0..DEPTH-2)
// PORTS
//  clk             in   1           single clock, rising edge
//  arst_n          in   1           asynchronous, active-low reset
//  we_i            in   1           write request
//  data_w          in   DATA_WIDTH  write data, sampled with we_i
//  re_i            in   1           read request
//  data_r          out  DATA_WIDTH  read data (registered)
//  full_o          out  1           level == DEPTH
//  empty_o         out  1           level == 0
//  almost_full_o   out  1           level >= AFULL_THRESH
//  almost_empty_o  out  1           level <= AEMPTY_THRESH
//  level_o         out  AW+1        occupancy 0..DEPTH, AW = $clog2(DEPTH)
//  overflow_o      out  1           sticky; present only with SYNC_FIFO_ERR_EN
//  underflow_o     out  1           sticky; present only with SYNC_FIFO_ERR_EN
// BEHAVIOUR
//  - Reset (arst_n low, async assert, sync release): wr_ptr = rd_ptr = 0, level_o = 0,
//    data_r = 0, empty_o = 1, almost_empty_o = 1, full_o = 0, almost_full_o = 0, error flags = 0.
//    Storage array is not reset. Reset mid-operation discards all contents immediately.
//  - rd_ok = re_i & ~empty_o.  wr_ok = we_i & (~full_o | rd_ok).
//  - Write on wr_ok: mem[wr_ptr] <= data_w; wr_ptr increments, wrapping DEPTH-1 -> 0.
//  - Read on rd_ok: data_r <= mem[rd_ptr] at that edge (1-cycle latency); rd_ptr increments with wrap.
//    data_r holds its last value when no read is accepted.
//  - Full with simultaneous read and write: both accepted; level stays DEPTH.
//  - Empty with simultaneous read and write: write only; no bypass; data_r unchanged; level -> 1.
//  - level_o: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. All flags are
//    registered and derived from next-level, so they are valid in the cycle after the causing edge.
//  - Rejected write when full or rejected read when empty: no state change (pointers, level, data).
// CONFIGURATION
//  SYNC_FIFO_ERR_EN defined: overflow_o sets on we_i & ~wr_ok; underflow_o sets on re_i & empty_o.
//    Both flags are sticky until arst_n. Ports exist only under the macro.
//  SYNC_FIFO_ERR_EN undefined: the ports and logic are absent; rejected requests are silently dropped.
// STRUCTURE
//  fifo_pkg: DATA_WIDTH_DEF = 32, DEPTH_DEF = 16, and the helper function
//    f_level_w(depth) = $clog2(depth) + 1, shared with afifo.
//  Sub-module sync_fifo_mem: DEPTH x DATA_WIDTH array with one write port and one registered read port
//    (we, waddr, wdata, re, raddr, rdata). sync_fifo holds the pointers, the level, the flags,
//    and the error logic.
// TESTING (DATA_WIDTH=32, DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2)
//  1. Reset, then idle: empty_o = 1, almost_empty_o = 1, level_o = 0, data_r = 0.
//  2. Write 0xfeedbeef, 0x1, ..., 0x7 (8 writes) -> level_o = 8, full_o = 1, almost_full_o = 1 after
//     6 writes. 9th write -> ignored; overflow_o = 1 (with macro).
//  3. Read 8 entries -> data_r = 0xfeedbeef then 0x1..0x7 in order, each 1 cycle after re_i.
//     empty_o = 1 after the last read. Extra read -> data_r holds 0x7; underflow_o = 1 (with macro).
//  4. Full, we_i = re_i = 1 with 0xa5a5a5a5 -> head is returned, level_o stays 8.
//     0xa5a5a5a5 is returned 8 reads later.
//  5. Empty, we_i = re_i = 1 with 0x12345678 -> level_o = 1, data_r unchanged.
//     Next read returns 0x12345678.
//  6. Write 20 entries interleaved with reads so the pointers wrap twice -> data order preserved.
//     Drop arst_n mid-stream -> outputs return to reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared FIFO defaults, level-width helper and request encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int DEPTH_DEF      = 16;

  // Accepted-request pair for one edge, encoded as {wr_ok, rd_ok}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

  function automatic int f_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
// sync_fifo_mem : DEPTH x DATA_WIDTH storage, one write port, registered read
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  input  logic                       re_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]      rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read samples the pre-edge contents, so a same-address write lands after.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : sync_fifo_mem

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock FIFO with occupancy level and almost-full/empty flags
// Optional macro SYNC_FIFO_ERR_EN adds sticky overflow_o / underflow_o. Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int DEPTH         = DEPTH_DEF,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       we_i,
  input  logic [DATA_WIDTH-1:0]      data_w,
  input  logic                       re_i,
  output logic [DATA_WIDTH-1:0]      data_r,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic [$clog2(DEPTH):0]     level_o
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic                       overflow_o,
  output logic                       underflow_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = f_level_w(DEPTH);

  localparam logic [AW-1:0] C_LAST_PTR   = AW'(DEPTH - 1);
  localparam logic [AW-1:0] C_ONE_PTR    = AW'(1);
  localparam logic [LW-1:0] C_DEPTH_LVL  = LW'(DEPTH);
  localparam logic [LW-1:0] C_ONE_LVL    = LW'(1);
  localparam logic [LW-1:0] C_AFULL_LVL  = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] C_AEMPTY_LVL = LW'(AEMPTY_THRESH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, empty_q, afull_q, aempty_q;
  logic          rd_ok, wr_ok;
  fifo_op_e      op;

  always_comb begin
    rd_ok    = re_i & ~empty_q;
    // A write into a full FIFO is fine when a read frees the head slot.
    wr_ok    = we_i & (~full_q | rd_ok);
    op       = fifo_op_e'({wr_ok, rd_ok});
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (wr_ok) begin
      wr_ptr_d = (wr_ptr_q == C_LAST_PTR) ? '0 : wr_ptr_q + C_ONE_PTR;
    end
    if (rd_ok) begin
      rd_ptr_d = (rd_ptr_q == C_LAST_PTR) ? '0 : rd_ptr_q + C_ONE_PTR;
    end

    case (op)
      OP_WR:   level_d = level_q + C_ONE_LVL;
      OP_RD:   level_d = level_q - C_ONE_LVL;
      default: level_d = level_q;
    endcase
  end

  // Flags are registered from the next level so they line up with level_o.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == C_DEPTH_LVL);
      empty_q  <= (level_d == '0);
      afull_q  <= (level_d >= C_AFULL_LVL);
      aempty_q <= (level_d <= C_AEMPTY_LVL);
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .arst_n  (arst_n),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_w),
    .re_i    (rd_ok),
    .raddr_i (rd_ptr_q),
    .rdata_o (data_r)
  );

  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign level_o        = level_q;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (we_i & ~wr_ok) begin
        overflow_q <= 1'b1;
      end
      if (re_i & empty_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`endif

endmodule : sync_fifo

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
// tb_sync_fifo : randomized + directed bench for sync_fifo against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo;

  localparam int DW     = 32;
  localparam int DEPTH  = 8;
  localparam int AFULL  = 6;
  localparam int AEMPTY = 2;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          we_i, re_i;
  logic [DW-1:0] data_w, data_r;
  logic          full_o, empty_o, almost_full_o, almost_empty_o;
  logic [3:0]    level_o;
`ifdef SYNC_FIFO_ERR_EN
  logic          overflow_o, underflow_o;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_data;
  bit            exp_ovf, exp_unf;

  always #5 clk = ~clk;

  sync_fifo #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .AFULL_THRESH  (AFULL),
    .AEMPTY_THRESH (AEMPTY)
  ) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .we_i           (we_i),
    .data_w         (data_w),
    .re_i           (re_i),
    .data_r         (data_r),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .level_o        (level_o)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    int lvl;
    lvl = q.size();
    check_eq({ctx, ":level"},  32'(level_o),        32'(lvl));
    check_eq({ctx, ":full"},   32'(full_o),         32'(lvl == DEPTH));
    check_eq({ctx, ":empty"},  32'(empty_o),        32'(lvl == 0));
    check_eq({ctx, ":afull"},  32'(almost_full_o),  32'(lvl >= AFULL));
    check_eq({ctx, ":aempty"}, 32'(almost_empty_o), 32'(lvl <= AEMPTY));
    check_eq({ctx, ":data_r"}, data_r,              exp_data);
`ifdef SYNC_FIFO_ERR_EN
    check_eq({ctx, ":ovf"},    32'(overflow_o),     32'(exp_ovf));
    check_eq({ctx, ":unf"},    32'(underflow_o),    32'(exp_unf));
`endif
  endtask

  // One clock of requests; the model works from occupancy alone.
  task automatic step(input logic we, input logic [DW-1:0] d, input logic re, input string ctx);
    bit rd_acc, wr_acc;
    we_i   = we;
    data_w = d;
    re_i   = re;
    @(posedge clk);
    rd_acc = re && (q.size() != 0);
    wr_acc = we && ((q.size() < DEPTH) || rd_acc);
    if (we && !wr_acc) exp_ovf = 1'b1;
    if (re && q.size() == 0) exp_unf = 1'b1;
    if (rd_acc) exp_data = q.pop_front();
    if (wr_acc) q.push_back(d);
    #1;
    check_all(ctx);
  endtask

  task automatic model_reset();
    q.delete();
    exp_data = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  endtask

  initial begin
    int wp;
    arst_n = 1'b0;
    we_i   = 1'b0;
    re_i   = 1'b0;
    data_w = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    check_all("reset");
    step(1'b0, 32'h0, 1'b0, "idle");

    // Fill to full, then one rejected write.
    step(1'b1, 32'hfeedbeef, 1'b0, "fill");
    for (int i = 1; i < DEPTH; i++) step(1'b1, 32'(i), 1'b0, "fill");
    check_eq("full_after_8", 32'(full_o), 32'd1);
    step(1'b1, 32'hdeaddead, 1'b0, "over");

    // Drain, including one read past empty.
    step(1'b0, 32'h0, 1'b1, "drain");
    check_eq("head_value", data_r, 32'hfeedbeef);
    for (int i = 1; i < DEPTH; i++) step(1'b0, 32'h0, 1'b1, "drain");
    check_eq("last_value", data_r, 32'h7);
    step(1'b0, 32'h0, 1'b1, "under");
    check_eq("hold_value", data_r, 32'h7);

    // Full with simultaneous read and write.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, "refill");
    step(1'b1, 32'ha5a5a5a5, 1'b1, "full_rw");
    check_eq("full_rw_head", data_r, 32'h100);
    check_eq("full_rw_level", 32'(level_o), 32'd8);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 1'b1, "drain2");
    check_eq("a5_returned", data_r, 32'ha5a5a5a5);

    // Empty with simultaneous read and write: write only.
    step(1'b1, 32'h12345678, 1'b1, "empty_rw");
    check_eq("empty_rw_level", 32'(level_o), 32'd1);
    check_eq("empty_rw_hold", data_r, 32'ha5a5a5a5);
    step(1'b0, 32'h0, 1'b1, "empty_rw_rd");
    check_eq("bypass_free", data_r, 32'h12345678);

    // Randomized traffic with phases biased toward full and toward empty.
    for (int ph = 0; ph < 6; ph++) begin
      wp = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
      for (int c = 0; c < 60; c++) begin
        step(1'(($urandom_range(0, 99) < wp)), $urandom(),
             1'(($urandom_range(0, 99) >= wp - 10)), "rand");
      end
    end

    // Partially fill, then reset asynchronously between clock edges.
    for (int i = 0; i < 5; i++) step(1'b1, $urandom(), 1'(i % 2), "pre_rst");
    #2;
    arst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    we_i = 1'b0;
    re_i = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)), "post_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_sync_fifo

`default_nettype wire
